// File: rtl/spmv_csr_engine.sv
// CSR sparse matrix-vector engine: y = A*x, one signed fixed-point dot product per row.
// Latency: 2 cycles + 2 per nonzero per row; nonzero and vector reads are 1-cycle sync-read.
// Backpressure: EMIT holds y_valid, y_row, y_data and all addresses stable until y_ready.
// Optional feature: define SPMV_SAT_EN for saturating accumulation with a sticky ovf flag.
module spmv_csr_engine #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 48,
  parameter int IDX_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  num_rows,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  rowptr_addr,
  input  logic [IDX_W-1:0]  rowptr_rdata,
  output logic [IDX_W-1:0]  nz_addr,
  input  logic [DATA_W-1:0] nz_val,
  input  logic [IDX_W-1:0]  nz_col,
  output logic [IDX_W-1:0]  vec_addr,
  input  logic [DATA_W-1:0] vec_rdata,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [IDX_W-1:0]  y_row,
  output logic [ACC_W-1:0]  y_data,
  output logic              err,
  output logic              ovf
);

  typedef enum logic [2:0] {
    S_IDLE, S_PTR_B, S_PTR_E, S_NZ, S_MAC, S_EMIT, S_DONE
  } state_t;

  state_t                    state_q;
  logic                      busy_q, done_q, y_valid_q, err_q;
  logic [IDX_W-1:0]          rows_q, row_q, kb_q, ke_q, k_q;
  logic [IDX_W-1:0]          rowptr_addr_q, nz_addr_q, vec_addr_q;
  logic [IDX_W-1:0]          rowptr_addr_d, nz_addr_d, vec_addr_d;
  logic signed [DATA_W-1:0]  val_q;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [2*DATA_W-1:0] prod, shifted;
  logic signed [ACC_W-1:0]   term;
  logic                      clamp;

  // Full-width signed product, floor shift back to Q.FRAC_W.
  assign prod    = $signed({{DATA_W{val_q[DATA_W-1]}}, val_q}) *
                   $signed({{DATA_W{vec_rdata[DATA_W-1]}}, vec_rdata});
  assign shifted = prod >>> FRAC_W;

  generate
    if (ACC_W <= 2*DATA_W) begin : g_trunc
      assign term = shifted[ACC_W-1:0];
    end else begin : g_sext
      assign term = {{(ACC_W-2*DATA_W){shifted[2*DATA_W-1]}}, shifted};
    end
  endgenerate

`ifdef SPMV_SAT_EN
  logic                    ovf_q;
  logic signed [ACC_W:0]   sum;
  // Add with one guard bit; differing top bits mean the signed result left ACC_W range.
  always_comb begin
    sum   = {acc_q[ACC_W-1], acc_q} + {term[ACC_W-1], term};
    acc_d = sum[ACC_W-1:0];
    clamp = 1'b0;
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      clamp = 1'b1;
      acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
  assign ovf = ovf_q;
`else
  // Plain modulo-2^ACC_W accumulation.
  always_comb begin
    acc_d = acc_q + term;
    clamp = 1'b0;
  end
  assign ovf = 1'b0;
`endif

  // Memory addresses are issued on the cycle the FSM leaves a state so sync-read data lands in the next one.
  always_comb begin
    rowptr_addr_d = rowptr_addr_q;
    nz_addr_d     = nz_addr_q;
    vec_addr_d    = vec_addr_q;
    case (state_q)
      S_IDLE:  if (start && num_rows != '0) rowptr_addr_d = '0;
      S_PTR_B: rowptr_addr_d = row_q + IDX_W'(1);
      S_PTR_E: if (rowptr_rdata > kb_q) nz_addr_d = kb_q;
      S_NZ:    vec_addr_d = nz_col;
      S_MAC:   if (k_q + IDX_W'(1) != ke_q) nz_addr_d = k_q + IDX_W'(1);
      S_EMIT:  if (y_ready && row_q != rows_q - IDX_W'(1)) rowptr_addr_d = row_q + IDX_W'(2);
      default: ;
    endcase
  end

  // Row walker: row end pointer is reused as the next row's begin, so rowptr is read once per row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      y_valid_q     <= 1'b0;
      err_q         <= 1'b0;
      rows_q        <= '0;
      row_q         <= '0;
      kb_q          <= '0;
      ke_q          <= '0;
      k_q           <= '0;
      val_q         <= '0;
      acc_q         <= '0;
      rowptr_addr_q <= '0;
      nz_addr_q     <= '0;
      vec_addr_q    <= '0;
`ifdef SPMV_SAT_EN
      ovf_q         <= 1'b0;
`endif
    end else begin
      rowptr_addr_q <= rowptr_addr_d;
      nz_addr_q     <= nz_addr_d;
      vec_addr_q    <= vec_addr_d;
      case (state_q)
        S_IDLE: if (start) begin
          busy_q <= 1'b1;
          err_q  <= 1'b0;
`ifdef SPMV_SAT_EN
          ovf_q  <= 1'b0;
`endif
          rows_q <= num_rows;
          row_q  <= '0;
          if (num_rows == '0) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_PTR_B;
          end
        end
        S_PTR_B: begin
          kb_q    <= rowptr_rdata;
          state_q <= S_PTR_E;
        end
        S_PTR_E: begin
          ke_q  <= rowptr_rdata;
          acc_q <= '0;
          k_q   <= kb_q;
          if (rowptr_rdata <= kb_q) begin
            if (rowptr_rdata < kb_q) err_q <= 1'b1;
            y_valid_q <= 1'b1;
            state_q   <= S_EMIT;
          end else begin
            state_q <= S_NZ;
          end
        end
        S_NZ: begin
          val_q   <= nz_val;
          state_q <= S_MAC;
        end
        S_MAC: begin
          acc_q <= acc_d;
`ifdef SPMV_SAT_EN
          if (clamp) ovf_q <= 1'b1;
`endif
          k_q <= k_q + IDX_W'(1);
          if (k_q + IDX_W'(1) == ke_q) begin
            y_valid_q <= 1'b1;
            state_q   <= S_EMIT;
          end else begin
            state_q <= S_NZ;
          end
        end
        S_EMIT: if (y_ready) begin
          y_valid_q <= 1'b0;
          if (row_q == rows_q - IDX_W'(1)) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            row_q   <= row_q + IDX_W'(1);
            kb_q    <= ke_q;
            state_q <= S_PTR_E;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign y_valid     = y_valid_q;
  assign y_row       = row_q;
  assign y_data      = acc_q;
  assign err         = err_q;
  assign rowptr_addr = rowptr_addr_d;
  assign nz_addr     = nz_addr_d;
  assign vec_addr    = vec_addr_d;

endmodule

// File: tb/tb_spmv_csr_engine.sv
// Directed bench for spmv_csr_engine: sync-read memory models, a reference dot-product model
// feeding a scoreboard queue, and in-order comparison of every accepted result.
module tb_spmv_csr_engine;

  logic        clk = 1'b0;
  logic        rst_n, start, y_ready;
  logic [15:0] num_rows;
  logic        busy, done, y_valid, err, ovf;
  logic [15:0] rowptr_addr, nz_addr, vec_addr, y_row;
  logic [15:0] rowptr_rdata, nz_col;
  logic [31:0] nz_val, vec_rdata;
  logic [47:0] y_data;

  logic [15:0] rp_mem  [256];
  logic [31:0] val_mem [256];
  logic [15:0] col_mem [256];
  logic [31:0] x_mem   [256];

  typedef struct {
    logic [15:0] row;
    logic [47:0] data;
  } sb_t;
  sb_t sb[$];

  int n_vec = 0;
  int n_err = 0;
  bit exp_err, exp_ovf;

  spmv_csr_engine #(.DATA_W(32), .FRAC_W(8), .ACC_W(48), .IDX_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
    .busy(busy), .done(done),
    .rowptr_addr(rowptr_addr), .rowptr_rdata(rowptr_rdata),
    .nz_addr(nz_addr), .nz_val(nz_val), .nz_col(nz_col),
    .vec_addr(vec_addr), .vec_rdata(vec_rdata),
    .y_valid(y_valid), .y_ready(y_ready), .y_row(y_row), .y_data(y_data),
    .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Sync-read memories: data for an address seen at a rising edge appears after that edge.
  always @(posedge clk) begin
    rowptr_rdata <= rp_mem[rowptr_addr[7:0]];
    nz_val       <= val_mem[nz_addr[7:0]];
    nz_col       <= col_mem[nz_addr[7:0]];
    vec_rdata    <= x_mem[vec_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic signed [47:0] term_f(input logic signed [31:0] v, input logic signed [31:0] xx);
    longint p;
    logic [63:0] s;
    p = longint'(v) * longint'(xx);
    s = p >>> 8;
    return s[47:0];
  endfunction

  // Reference model: walk the CSR arrays and queue one expected result per row.
  task automatic build_expect(input int n);
    int kb, ke;
    logic signed [47:0] acc, t;
    longint s;
    sb.delete();
    exp_err = 1'b0;
    exp_ovf = 1'b0;
    for (int r = 0; r < n; r++) begin
      kb = int'(rp_mem[r]);
      ke = int'(rp_mem[r+1]);
      acc = '0;
      if (ke < kb) exp_err = 1'b1;
      for (int k = kb; k < ke; k++) begin
        t = term_f(val_mem[k], x_mem[col_mem[k][7:0]]);
        s = longint'(acc) + longint'(t);
`ifdef SPMV_SAT_EN
        if (s > 64'sd140737488355327) begin
          s = 64'sd140737488355327; exp_ovf = 1'b1;
        end else if (s < -64'sd140737488355328) begin
          s = -64'sd140737488355328; exp_ovf = 1'b1;
        end
`endif
        acc = s[47:0];
      end
      sb.push_back('{row: 16'(r), data: acc});
    end
  endtask

  // One pass: start, consume results with optional per-row stall, check against the scoreboard.
  task automatic run_pass(input int n, input int stall, input bit mid_start);
    int stall_left, done_cnt;
    bit fin;
    sb_t e;
    build_expect(n);
    @(negedge clk); start = 1'b1; num_rows = 16'(n);
    @(negedge clk); start = 1'b0;
    stall_left = stall; done_cnt = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (mid_start && cyc == 2) begin start = 1'b1; num_rows = 16'd0; end
      else start = 1'b0;
      if (done) begin
        done_cnt++; fin = 1'b1; y_ready = 1'b0;
      end else if (y_valid) begin
        if (sb.size() == 0) begin
          y_ready = 1'b0;
          chk("extra_y_valid", {63'd0, y_valid}, 64'd0);
        end else if (stall_left > 0) begin
          y_ready = 1'b0;
          stall_left--;
          chk("stall_row", y_row, sb[0].row);
          chk("stall_data", y_data, sb[0].data);
          chk("stall_rowptr_addr", rowptr_addr, sb[0].row + 16'd1);
        end else begin
          y_ready = 1'b1;
          e = sb.pop_front();
          chk("y_row", y_row, e.row);
          chk("y_data", y_data, e.data);
          stall_left = stall;
        end
      end else begin
        y_ready = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; y_ready = 1'b0;
    chk("done_pulses", done_cnt, 1);
    chk("rows_left", sb.size(), 0);
    chk("done_dropped", {63'd0, done}, 64'd0);
    chk("busy_after", {63'd0, busy}, 64'd0);
    chk("err", {63'd0, err}, {63'd0, exp_err});
    chk("ovf", {63'd0, ovf}, {63'd0, exp_ovf});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; y_ready = 1'b0; num_rows = '0;
    for (int i = 0; i < 256; i++) begin
      rp_mem[i] = '0; val_mem[i] = '0; col_mem[i] = '0; x_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_y_valid", {63'd0, y_valid}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_rowptr_addr", rowptr_addr, 64'd0);
    chk("rst_y_data", y_data, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Diagonal 3x3, identity scaled by x; a start pulse mid-pass must be ignored.
    for (int i = 0; i < 4; i++) rp_mem[i] = 16'(i);
    for (int i = 0; i < 3; i++) begin val_mem[i] = 32'd256; col_mem[i] = 16'(i); end
    x_mem[0] = 32'd512; x_mem[1] = 32'd768; x_mem[2] = 32'd1024;
    run_pass(3, 0, 1'b1);
    chk("diag_y2_model", sb.size(), 0);

    // Same matrix with the sink stalling 5 cycles on every row.
    run_pass(3, 5, 1'b0);

    // Empty row in the middle plus a negative coefficient.
    rp_mem[0] = 16'd0; rp_mem[1] = 16'd2; rp_mem[2] = 16'd2; rp_mem[3] = 16'd3;
    val_mem[0] = 32'hFFFF_FF00; val_mem[1] = 32'd256; val_mem[2] = 32'd256;
    col_mem[0] = 16'd0; col_mem[1] = 16'd1; col_mem[2] = 16'd2;
    x_mem[0] = 32'd1; x_mem[1] = 32'd3; x_mem[2] = 32'd5;
    run_pass(3, 0, 1'b0);

    // Zero-row pass: busy for one cycle alongside the done pulse, no results.
    @(negedge clk); start = 1'b1; num_rows = 16'd0;
    @(negedge clk); start = 1'b0;
    chk("zero_busy", {63'd0, busy}, 64'd1);
    chk("zero_done", {63'd0, done}, 64'd1);
    chk("zero_y_valid", {63'd0, y_valid}, 64'd0);
    @(negedge clk);
    chk("zero_busy_end", {63'd0, busy}, 64'd0);
    chk("zero_done_end", {63'd0, done}, 64'd0);
    chk("zero_y_valid_end", {63'd0, y_valid}, 64'd0);

    // Large products: full-scale operands, and 2^27*2^27 terms that exceed ACC_W when summed.
    rp_mem[0] = 16'd0; rp_mem[1] = 16'd4; rp_mem[2] = 16'd7;
    for (int i = 0; i < 4; i++) begin
      val_mem[i] = 32'h7FFF_FFFF; col_mem[i] = 16'(i); x_mem[i] = 32'h7FFF_FFFF;
    end
    for (int i = 4; i < 7; i++) begin
      val_mem[i] = 32'h0800_0000; col_mem[i] = 16'(i); x_mem[i] = 32'h0800_0000;
    end
    run_pass(2, 0, 1'b0);

    // Malformed row pointers: second row ends before it begins.
    rp_mem[0] = 16'd0; rp_mem[1] = 16'd3; rp_mem[2] = 16'd1;
    for (int i = 0; i < 3; i++) begin
      val_mem[i] = 32'(256 * (i + 1)); col_mem[i] = 16'(i); x_mem[i] = 32'(10 * (i + 1));
    end
    run_pass(2, 1, 1'b0);

    // Reset in the middle of accumulation, then a clean rerun of row 0.
    rp_mem[0] = 16'd0; rp_mem[1] = 16'd8;
    for (int i = 0; i < 8; i++) begin
      val_mem[i] = 32'd256; col_mem[i] = 16'(i); x_mem[i] = 32'(i + 1);
    end
    @(negedge clk); start = 1'b1; num_rows = 16'd1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_y_valid", {63'd0, y_valid}, 64'd0);
    chk("mid_rst_done", {63'd0, done}, 64'd0);
    chk("mid_rst_nz_addr", nz_addr, 64'd0);
    chk("mid_rst_vec_addr", vec_addr, 64'd0);
    chk("mid_rst_y_data", y_data, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_pass(1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
